adder_stim_check: RTL and testbench
===================================

# adder_stim_check

Self-checking stimulus source for the registered `adder_top` benchmark family, acting as the opposite end of its `a`/`b`/`sum` interface. On `start` it drives a fixed-length sequence of operand pairs: four directed corner vectors, then LFSR-generated vectors. It predicts each sum, aligns the prediction to the DUT pipeline latency, compares it against the returned `sum`, and reports pass/fail, an error count and the first failing vector index. It is instantiated beside the adder in on-chip benchmark harnesses.

## Interface
- `WIDTH`, 19: operand width; legal range 1..32.
- `LATENCY`, 2: number of clock edges from a change on `a`/`b` until the DUT's `sum` register updates.
- `NUM_VECTORS`, 1024: total vectors per run; must be ≥4 and ≤65535.
- `SEED`, 32'hACE1_2468: nonzero LFSR seed.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a run; sampled only in IDLE or DONE.
- `a`  out  WIDTH  operand A, registered.
- `b`  out  WIDTH  operand B, registered.
- `sum`  in  WIDTH+1  DUT result.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high when `done` is high and `err_count` is 0.
- `err_count`  out  16  mismatch count; saturates at 16'hFFFF.
- `first_err_idx`  out  16  index of the first mismatching vector; 0 if there were no errors.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start`. On that edge the block:
  - clears the counters;
  - loads `lfsr_a` = SEED and `lfsr_b` = ~SEED;
  - drives vector 0 on `a`/`b`;
  - sets the index counter to 1.
- RUN issues one vector per edge. The vector driven at the edge where the index counter equals NUM_VECTORS−1 is the last; at that same edge the state moves to DRAIN.
- DRAIN waits until every outstanding vector has been checked, then moves to DONE.
- DONE holds all results. `start` in DONE is a full restart, identical to the IDLE→RUN transition. `start` in RUN or DRAIN is ignored.
- `a`/`b` are 0 in IDLE, DRAIN and DONE.
- Vector i:
  - i=0: a=0, b=0.
  - i=1: a=all-ones, b=all-ones.
  - i=2: a=all-ones, b=1.
  - i=3: a=…0101 (bit0=1), b=…1010.
  - i≥4: a=lfsr_a[WIDTH-1:0], b=lfsr_b[WIDTH-1:0].
- LFSRs: 32-bit Galois, taps 32'h8020_0003. They step once per issued vector with i≥3, so the first random vector is one step past the seed.
- Expected value: a+b, WIDTH+1 bits, zero-extended with no truncation.
- Expected pipeline: LATENCY+1 stages, each holding {valid, expected, index}. Stage 0 is loaded on the same edge as `a`/`b`; a bubble is loaded when no vector is issued.
- Compare: at each edge where the last stage is valid, compare `sum` with its expected value.
  - On mismatch: `err_count` increments (saturating).
  - If `err_count` was 0, `first_err_idx` takes the stage's index.

## Timing
- Reset values: state IDLE, `a`=`b`=0, `busy`=`done`=`pass`=0, `err_count`=0, `first_err_idx`=0, all pipeline valid bits 0, LFSRs = SEED/~SEED. Reset has effect immediately, mid-run included.
- A vector driven at edge E is checked against `sum` as sampled at edge E+LATENCY+1.
- With `start` sampled at edge S:
  - vectors are driven at edges S..S+NUM_VECTORS−1;
  - the last compare happens at edge S+NUM_VECTORS+LATENCY;
  - at that same edge the state becomes DONE, so `done` is high from then on.
  - `busy` is high from after edge S until that edge.
- A mismatch on the final compare is counted before `done` rises.
- Saturation: `err_count` at 16'hFFFF stays at 16'hFFFF on further mismatches; `first_err_idx` is unaffected.
- Outputs are stable while in DONE.

## Test plan
- **Correct DUT.** `adder_top` with WIDTH=19, LATENCY=2; pulse `start` at edge S.
  - Expect `done` at edge S+1026, `pass`=1, `err_count`=0.
- **Corner values.** Check cycle-by-cycle after S.
  - `a`/`b` = 0/0, then 0x7FFFF/0x7FFFF (expected 0xFFFFE), then 0x7FFFF/1 (expected 0x80000), then 0x55555/0x2AAAA.
- **Stuck bit.** DUT with `sum[5]` stuck at 0.
  - Expect `pass`=0, `err_count`>0, `first_err_idx`=1.
- **Wrong latency.** Correct DUT with the checker built for LATENCY=3.
  - Expect `err_count`>0, `first_err_idx`=0 only if sum misalignment differs, otherwise 1.
  - Expect `done` at S+1027.
- **Reset mid-run.** Assert `reset` in RUN at vector 500.
  - Expect all outputs at reset values immediately.
  - A new `start` reproduces vector 0 and the identical sequence.
- **Restart and ignore.** Pulse `start` in DONE; also pulse `start` during RUN.
  - The DONE pulse clears the counters and regenerates a bit-identical `a`/`b` sequence.
  - The RUN pulse has no effect: same `done` edge, same results.

Source files
------------

// File: rtl/adder_stim_check.sv
// adder_stim_check
//   Stimulus source and checker for a registered adder under test. On start it
//   drives NUM_VECTORS operand pairs: four corner vectors, then LFSR-derived
//   vectors. Each vector's expected sum travels down a LATENCY+1 deep pipeline
//   and is compared against the returned sum when it reaches the last stage.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          begins (or restarts) a run; honoured only in IDLE or DONE
//   a, b           registered operands to the adder (WIDTH bits)
//   sum            adder result (WIDTH+1 bits)
//   busy           high while vectors are issued or still outstanding
//   done           high once every vector has been checked
//   pass           done with zero mismatches
//   err_count      saturating mismatch count
//   first_err_idx  index of the first mismatching vector, 0 if none
`timescale 1ns/1ps

module adder_stim_check #(
  parameter int          WIDTH       = 19,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Right-shifting Galois LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

  // Alternating bit pattern; lsb selects the value of bit 0.
  function automatic logic [WIDTH-1:0] alt_pattern(input logic lsb);
    logic [WIDTH-1:0] p;
    for (int k = 0; k < WIDTH; k++) begin
      p[k] = k[0] ^ lsb;
    end
    alt_pattern = p;
  endfunction

  // Full-width sum, no truncation of the carry.
  function automatic logic [WIDTH:0] full_sum(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    full_sum = {1'b0, x} + {1'b0, y};
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [15:0]      r_idx;
  logic [31:0]      r_lfsr_a;
  logic [31:0]      r_lfsr_b;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [15:0]      r_err_count;
  logic [15:0]      r_first_err_idx;

  logic [LATENCY:0] r_vld;
  logic [WIDTH:0]   r_exp  [LATENCY+1];
  logic [15:0]      r_pidx [LATENCY+1];

  logic             w_start;
  logic             w_issue;
  logic             w_last;
  logic [15:0]      w_cur_idx;
  logic [WIDTH-1:0] w_vec_a;
  logic [WIDTH-1:0] w_vec_b;
  logic [WIDTH:0]   w_vec_exp;
  logic             w_older_vld;
  logic             w_drained;
  logic             w_miss;

  // A start pulse is only meaningful when no run is in flight.
  assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue   = w_start || (r_state == S_RUN);
  assign w_last    = (r_state == S_RUN) && (r_idx == LAST_IDX);
  assign w_cur_idx = w_start ? 16'd0 : r_idx;

  // Vector for the index being issued this edge; zeros when nothing is issued.
  always_comb begin
    w_vec_a = '0;
    w_vec_b = '0;
    if (w_issue) begin
      if (w_cur_idx == 16'd0) begin
        w_vec_a = '0;
        w_vec_b = '0;
      end else if (w_cur_idx == 16'd1) begin
        w_vec_a = '1;
        w_vec_b = '1;
      end else if (w_cur_idx == 16'd2) begin
        w_vec_a = '1;
        w_vec_b = WIDTH'(1);
      end else if (w_cur_idx == 16'd3) begin
        w_vec_a = alt_pattern(1'b1);
        w_vec_b = alt_pattern(1'b0);
      end else begin
        w_vec_a = r_lfsr_a[WIDTH-1:0];
        w_vec_b = r_lfsr_b[WIDTH-1:0];
      end
    end
  end

  assign w_vec_exp = full_sum(w_vec_a, w_vec_b);

  // The final compare is the one with no valid entries behind it.
  always_comb begin
    w_older_vld = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      w_older_vld = w_older_vld | r_vld[k];
    end
  end

  assign w_drained = r_vld[LATENCY] && !w_older_vld;
  assign w_miss    = r_vld[LATENCY] && (sum != r_exp[LATENCY]);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start)   w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DRAIN;
      S_DRAIN: if (w_drained) w_next_state = S_DONE;
      S_DONE:  if (w_start)   w_next_state = S_RUN;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
    pass = (r_state == S_DONE) && (r_err_count == 16'd0);
  end

  // Issue stage: index counter, LFSRs and operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= 16'd0;
      r_lfsr_a <= SEED;
      r_lfsr_b <= ~SEED;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_a <= w_vec_a;
      r_b <= w_vec_b;
      if (w_start) begin
        r_idx    <= 16'd1;
        r_lfsr_a <= SEED;
        r_lfsr_b <= ~SEED;
      end else if (r_state == S_RUN) begin
        r_idx <= r_idx + 16'd1;
        // Stepping from vector 3 onward makes vector 4 one step past the seed.
        if (r_idx >= 16'd3) begin
          r_lfsr_a <= lfsr_step(r_lfsr_a);
          r_lfsr_b <= lfsr_step(r_lfsr_b);
        end
      end
    end
  end

  assign a = r_a;
  assign b = r_b;

  // Expectation pipeline: valid bits are reset, payload is not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int k = 1; k <= LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_exp[0]  <= w_vec_exp;
    r_pidx[0] <= w_cur_idx;
    for (int k = 1; k <= LATENCY; k++) begin
      r_exp[k]  <= r_exp[k-1];
      r_pidx[k] <= r_pidx[k-1];
    end
  end

  // Compare stage: error counting against the returned sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count     <= 16'd0;
      r_first_err_idx <= 16'd0;
    end else if (w_start) begin
      r_err_count     <= 16'd0;
      r_first_err_idx <= 16'd0;
    end else if (w_miss) begin
      if (r_err_count != 16'hFFFF) begin
        r_err_count <= r_err_count + 16'd1;
      end
      if (r_err_count == 16'd0) begin
        r_first_err_idx <= r_pidx[LATENCY];
      end
    end
  end

  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_adder_stim_check.sv
// tb_adder_stim_check
//   Drives adder_stim_check against a small behavioural adder whose latency
//   and a stuck-at fault on sum[5] can be switched between runs. Expected
//   operand sequences and run results come from a reference model built from
//   the vector rules with plain arithmetic.
`timescale 1ns/1ps

module tb_adder_stim_check;

  localparam int          W    = 19;
  localparam int          L    = 2;
  localparam int          N    = 1024;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W:0]    sum;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [15:0]   first_err_idx;

  int total = 0;
  int bad   = 0;

  // Adder model: two registers normally, a third when lat3 is set.
  logic       stuck5 = 1'b0;
  logic       lat3   = 1'b0;
  logic [W:0] r1 = '0;
  logic [W:0] r2 = '0;
  logic [W:0] r3 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1 <= {1'b0, a} + {1'b0, b};
    r2 <= r1;
    r3 <= r2;
  end

  assign sum = (lat3 ? r3 : r2) & ~(stuck5 ? (W+1)'(32'h20) : (W+1)'(32'h0));

  adder_stim_check #(
    .WIDTH(W), .LATENCY(L), .NUM_VECTORS(N), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .sum(sum),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  // Reference vectors and their true sums.
  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];
  logic [W:0]   ve [N];

  function automatic logic [31:0] step(input logic [31:0] s);
    step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: correct adder, 1: sum[5] stuck at 0, 2: adder one cycle slower.
  task automatic model_results(input int mode, output int e_cnt, output int e_first);
    logic [W:0] seen;
    e_cnt   = 0;
    e_first = 0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        1:       seen = ve[i] & ~(W+1)'(32'h20);
        2:       seen = (i == 0) ? '0 : ve[i-1];
        default: seen = ve[i];
      endcase
      if (seen != ve[i]) begin
        if (e_cnt == 0) e_first = i;
        if (e_cnt < 65535) e_cnt++;
      end
    end
  endtask

  task automatic do_run(input int mode, input int ign_k, input int rst_k);
    int           e_cnt;
    int           e_first;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    stuck5 = (mode == 1);
    lat3   = (mode == 2);
    model_results(mode, e_cnt, e_first);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= N + L + 2; k++) begin
      if (k == rst_k) begin
        reset = 1'b1;
        #1;
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      ea = (k < N) ? va[k] : '0;
      eb = (k < N) ? vb[k] : '0;
      chk("a", a, ea);
      chk("b", b, eb);
      chk("busy", busy, (k < N + L) ? 1 : 0);
      chk("done", done, (k >= N + L) ? 1 : 0);
      if (k == 0) begin
        chk("clr_err", err_count, 0);
        chk("clr_first", first_err_idx, 0);
      end
      start = (k == ign_k);
      @(negedge clk);
    end
    start = 1'b0;
    chk("err_count", err_count, e_cnt);
    chk("first_err_idx", first_err_idx, e_first);
    chk("pass", pass, (e_cnt == 0) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] la;
    logic [31:0] lb;
    la = SEED;
    lb = ~SEED;
    for (int i = 0; i < N; i++) begin
      case (i)
        0: begin va[i] = '0; vb[i] = '0; end
        1: begin va[i] = '1; vb[i] = '1; end
        2: begin va[i] = '1; vb[i] = W'(1); end
        3: begin va[i] = W'(32'h5555_5555); vb[i] = W'(32'hAAAA_AAAA); end
        default: begin
          la = step(la);
          lb = step(lb);
          va[i] = la[W-1:0];
          vb[i] = lb[W-1:0];
        end
      endcase
      ve[i] = {1'b0, va[i]} + {1'b0, vb[i]};
    end

    // Reset state.
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_a", a, 0);
    chk("init_b", b, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_pass", pass, 0);
    chk("init_err", err_count, 0);
    chk("init_first", first_err_idx, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Correct adder, with a start pulse during RUN that must be ignored.
    do_run(0, $urandom_range(5, N - 10), -1);
    // Restart from DONE with a stuck sum bit.
    do_run(1, -1, -1);
    // Restart from DONE with a correct adder: counters must clear.
    do_run(0, -1, -1);
    repeat ($urandom_range(4, 12)) @(negedge clk);
    // Adder one cycle slower than the checker expects.
    do_run(2, -1, -1);
    repeat ($urandom_range(4, 12)) @(negedge clk);
    // Reset in the middle of a run, then a full clean run.
    do_run(0, -1, 500);
    lat3   = 1'b0;
    stuck5 = 1'b0;
    repeat ($urandom_range(4, 12)) @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    do_run(0, $urandom_range(5, N - 10), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
